// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_pkg
//  Purpose  : Shared types and defaults for the interrupt pending controller.
//  Revision : 1.0 - initial release
// ============================================================================
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam int INT_N_SRC_DFLT = 4;

endpackage : int_pkg
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : int_prio_enc
//  Purpose  : Combinational priority encoder, lowest set index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module int_prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  // Scan downward so the last (lowest) set bit overwrites higher ones.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule : int_prio_enc
`default_nettype wire

// File: rtl/int_pend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : int_pend_ctrl
//  Purpose  : Edge-captured sticky interrupt pending bits with mask, overrun
//             tracking and a single prioritised request to the control unit.
//  Revision : 1.0 - initial release
// ============================================================================
module int_pend_ctrl
  import int_pkg::*;
#(
  parameter int N_SRC = INT_N_SRC_DFLT,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] int_req,
  input  logic [N_SRC-1:0] int_mask,
  input  logic             i_flag,
  input  logic             int_ack,
  input  logic             ovr_clr,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pend,
  output logic [N_SRC-1:0] ovr
);

  localparam logic [N_SRC-1:0] c_one = N_SRC'(1);

  int_state_t       r_state;
  int_state_t       w_state_nxt;
  logic [N_SRC-1:0] r_req_q;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_ovr;
  logic [ID_W-1:0]  r_irq_id;
  logic [ID_W-1:0]  w_id_nxt;
  logic [N_SRC-1:0] w_ev;
  logic [N_SRC-1:0] w_ret;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_ovr_set;
  logic [ID_W-1:0]  w_win;
  logic             w_win_vld;

  assign w_ev      = int_req & ~r_req_q;
  assign w_elig    = r_pend & int_mask;
  assign w_ret     = (r_state == REQ && int_ack) ? (c_one << r_irq_id) : '0;
  assign w_ovr_set = w_ev & r_pend & ~w_ret;

  int_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .vec   (w_elig),
    .idx   (w_win),
    .valid (w_win_vld)
  );

  // A new event on a retiring source re-pends it: set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q <= '0;
      r_pend  <= '0;
      r_ovr   <= '0;
    end else begin
      r_req_q <= int_req;
      r_pend  <= (r_pend & ~w_ret) | w_ev;
      r_ovr   <= (ovr_clr ? '0 : r_ovr) | w_ovr_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq_id <= w_id_nxt;
    end
  end

  // The id is latched only on IDLE->REQ so it stays stable for the whole request.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_irq_id;
    case (r_state)
      IDLE: begin
        if (i_flag && w_win_vld) begin
          w_state_nxt = REQ;
          w_id_nxt    = w_win;
        end
      end
      REQ: begin
        if (int_ack)                          w_state_nxt = SERVICE;
        else if (!i_flag || !w_elig[r_irq_id]) w_state_nxt = IDLE;
      end
      SERVICE: begin
        if (!i_flag) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign irq    = (r_state == REQ);
  assign irq_id = r_irq_id;
  assign pend   = r_pend;
  assign ovr    = r_ovr;

endmodule : int_pend_ctrl
`default_nettype wire

// File: tb/tb_int_pend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_pend_ctrl
//  Purpose  : Directed vector bench for int_pend_ctrl (N_SRC = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_pend_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] int_req;
  logic [3:0] int_mask;
  logic       i_flag;
  logic       int_ack;
  logic       ovr_clr;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pend;
  logic [3:0] ovr;

  int n_checks = 0;
  int n_errors = 0;

  // chk bits: 0 irq, 1 irq_id, 2 pend, 3 ovr
  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       flag;
    logic       ack;
    logic       clr;
    logic [3:0] chk;
    logic       e_irq;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic [3:0] e_ovr;
  } vec_t;

  vec_t vq[$];

  int_pend_ctrl #(.N_SRC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .int_req  (int_req),
    .int_mask (int_mask),
    .i_flag   (i_flag),
    .int_ack  (int_ack),
    .ovr_clr  (ovr_clr),
    .irq      (irq),
    .irq_id   (irq_id),
    .pend     (pend),
    .ovr      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addv(input logic [3:0] req, input logic [3:0] mask, input logic flag,
                      input logic ack, input logic clr, input logic [3:0] chk,
                      input logic e_irq, input logic [1:0] e_id,
                      input logic [3:0] e_pend, input logic [3:0] e_ovr);
    vec_t v;
    v.req = req; v.mask = mask; v.flag = flag; v.ack = ack; v.clr = clr;
    v.chk = chk; v.e_irq = e_irq; v.e_id = e_id; v.e_pend = e_pend; v.e_ovr = e_ovr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] chk, input logic e_irq,
                       input logic [1:0] e_id, input logic [3:0] e_pend, input logic [3:0] e_ovr);
    if (chk[0]) begin
      n_checks++;
      if (irq !== e_irq) begin
        n_errors++;
        $display("FAIL %s irq got %b want %b", name, irq, e_irq);
      end
    end
    if (chk[1]) begin
      n_checks++;
      if (irq_id !== e_id) begin
        n_errors++;
        $display("FAIL %s irq_id got %0d want %0d", name, irq_id, e_id);
      end
    end
    if (chk[2]) begin
      n_checks++;
      if (pend !== e_pend) begin
        n_errors++;
        $display("FAIL %s pend got %b want %b", name, pend, e_pend);
      end
    end
    if (chk[3]) begin
      n_checks++;
      if (ovr !== e_ovr) begin
        n_errors++;
        $display("FAIL %s ovr got %b want %b", name, ovr, e_ovr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; int_req = '0; int_mask = 4'b1111; i_flag = 1'b0; int_ack = 1'b0; ovr_clr = 1'b0;

    // columns: req mask flag ack clr | chk irq id pend ovr  (state after the edge)
    // pulse on [2] with ack, then rest of the pulse must not re-pend
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1101, 0, 0, 4'b0100, 4'b0000); // 0
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 1
    addv(4'b0100, 4'b1111, 1, 1, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 2 SERVICE
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 3 hold SERVICE
    addv(4'b0100, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 4 IDLE
    addv(4'b0100, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 5
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 6
    // 6-cycle pulse on [2], no ack: one event, request held
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1101, 0, 0, 4'b0100, 4'b0000); // 7
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 8
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 9
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 10
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 11
    addv(4'b0100, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 12
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000); // 13
    addv(4'b0000, 4'b1111, 1, 1, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 14
    addv(4'b0000, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 15
    // simultaneous events on [3] and [1]
    addv(4'b1010, 4'b1111, 1, 0, 0, 4'b1101, 0, 0, 4'b1010, 4'b0000); // 16
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 1, 4'b1010, 4'b0000); // 17
    addv(4'b0000, 4'b1111, 0, 1, 0, 4'b1101, 0, 0, 4'b1000, 4'b0000); // 18 SERVICE
    addv(4'b0000, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b1000, 4'b0000); // 19 IDLE
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 3, 4'b1000, 4'b0000); // 20 RETIE
    addv(4'b0000, 4'b1111, 1, 1, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 21
    addv(4'b0000, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 22
    // masked source still pends
    addv(4'b0001, 4'b1110, 1, 0, 0, 4'b1101, 0, 0, 4'b0001, 4'b0000); // 23
    addv(4'b0000, 4'b1110, 1, 0, 0, 4'b1101, 0, 0, 4'b0001, 4'b0000); // 24
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1100, 0, 0, 4'b0001, 4'b0000); // 25
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000); // 26
    addv(4'b0000, 4'b1111, 1, 1, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 27
    addv(4'b0000, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0000, 4'b0000); // 28
    // event coincident with retire, then overrun and clear
    addv(4'b0010, 4'b1111, 1, 0, 0, 4'b1101, 0, 0, 4'b0010, 4'b0000); // 29
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 1, 4'b0010, 4'b0000); // 30
    addv(4'b0010, 4'b1111, 1, 1, 0, 4'b1101, 0, 0, 4'b0010, 4'b0000); // 31
    addv(4'b0000, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0010, 4'b0000); // 32
    addv(4'b0010, 4'b1111, 0, 0, 0, 4'b1101, 0, 0, 4'b0010, 4'b0010); // 33
    addv(4'b0000, 4'b1111, 0, 0, 1, 4'b1101, 0, 0, 4'b0010, 4'b0000); // 34
    addv(4'b0010, 4'b1111, 0, 0, 1, 4'b1101, 0, 0, 4'b0010, 4'b0010); // 35 set wins
    addv(4'b0000, 4'b1111, 0, 0, 1, 4'b1101, 0, 0, 4'b0010, 4'b0000); // 36
    addv(4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 1, 4'b0010, 4'b0000); // 37 REQ

    #12;
    check("reset", 4'b1111, 1'b0, 2'd0, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      int_req  = vq[i].req;
      int_mask = vq[i].mask;
      i_flag   = vq[i].flag;
      int_ack  = vq[i].ack;
      ovr_clr  = vq[i].clr;
      @(posedge clk); #1;
      check($sformatf("row%0d", i), vq[i].chk, vq[i].e_irq, vq[i].e_id, vq[i].e_pend, vq[i].e_ovr);
    end

    // async reset mid-REQ, between edges
    int_ack = 1'b0; ovr_clr = 1'b0; int_req = 4'b0001;
    #2 rst = 1'b1;
    #1 check("async_rst", 4'b1111, 1'b0, 2'd0, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    check("rst_hold", 4'b1111, 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ev", 4'b1101, 1'b0, 2'd0, 4'b0001, 4'b0000);
    @(posedge clk); #1;
    check("post_rst_irq", 4'b1111, 1'b1, 2'd0, 4'b0001, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_int_pend_ctrl
`default_nettype wire
